issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

- Sits between instruction decode and the execute pipes (ALU, MUL/DIV, MEM, CTRL).
- Accepts one decoded instruction per cycle and tracks pending register writes in a 32-entry scoreboard.
- Holds the instruction until it is free of RAW/WAW hazards and its target pipe can accept it, then steers it to exactly one pipe.
- Per-pipe in-flight counters bound outstanding work; the writeback and completion ports retire entries.

## Interface

Parameters:
- NUM_PIPES, 4, number of execute pipes; pipe index width PW = $clog2(NUM_PIPES).
- MAX_INFLIGHT, 4, maximum issued-but-not-completed instructions per pipe; counter width CW = $clog2(MAX_INFLIGHT+1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- dec_val  input  1  decoded instruction valid.
- dec_rdy  output  1  instruction accepted this cycle.
- dec_raddr0  input  5  source register 0; 0 means no dependency.
- dec_raddr1  input  5  source register 1; 0 means no dependency.
- dec_waddr  input  5  destination register.
- dec_wen  input  1  instruction writes dec_waddr.
- dec_pipe  input  PW  target pipe index.
- iss_val  output  NUM_PIPES  one-hot issue valid.
- iss_rdy  input  NUM_PIPES  per-pipe ready.
- wb_val  input  1  writeback occurring.
- wb_waddr  input  5  writeback register.
- wb_wen  input  1  writeback writes the register file.
- cmpl_val  input  NUM_PIPES  per-pipe completion pulse; one instruction leaves that pipe.
- stall_raw  output  1  dec_val high and blocked by a RAW/WAW hazard.
- stall_struct  output  1  dec_val high, no hazard, but the pipe is unavailable.
- busy  output  1  any scoreboard bit set or any counter nonzero.

## Operation

- State:
  - pending[31:1], one bit per register; register 0 is never pending.
  - cnt[p], CW bits, for p in 0..NUM_PIPES-1.
- Hazard: hz = pend(dec_raddr0) | pend(dec_raddr1) | (dec_wen & pend(dec_waddr)).
  - pend(0) = 0.
  - pend(r) = pending[r], subject to the bypass rule in Configuration.
- Structural: avail = iss_rdy[dec_pipe] & (cnt[dec_pipe] < MAX_INFLIGHT).
- Fire: fire = dec_val & ~hz & avail.
  - dec_rdy = fire.
  - iss_val = fire ? (1 << dec_pipe) : 0.
  - Combinational in the same cycle.
- stall_raw = dec_val & hz.
- stall_struct = dec_val & ~hz & ~avail.
- dec_pipe >= NUM_PIPES is illegal: treat as avail = 0 and fire the simulation assertion.
- Scoreboard update at the edge:
  - set = fire & dec_wen & (dec_waddr != 0).
  - clr = wb_val & wb_wen & (wb_waddr != 0).
  - Set of register r takes priority over clear of r in the same cycle.
  - Clear of a non-pending register is a no-op.
- Counter update at the edge, for each p:
  - increment on iss_val[p] & iss_rdy[p]; decrement on cmpl_val[p].
  - Both in the same cycle leaves cnt unchanged.
  - cmpl_val[p] with cnt[p] == 0 leaves cnt at 0 and fires the simulation assertion.
- No FSM beyond the scoreboard and counters. The decoder holds the instruction while dec_rdy = 0; this block never buffers it.

## Timing

- Issue latency: 0 cycles. An unblocked instruction fires in the cycle it is presented.
- Pending bit visibility: set at the end of the issue cycle, so a dependent instruction presented the next cycle sees the hazard.
- Back-to-back independent instructions: one per cycle.
- Dependent instruction: earliest issue is the cycle after wb_val for its source, or the same cycle with bypass.
- cnt reaching MAX_INFLIGHT blocks that pipe from the next cycle. A same-cycle cmpl_val does not unblock until the following cycle.
- Reset: rst_n low asynchronously clears pending and all cnt. While rst_n is low, force dec_rdy, iss_val, stall_raw, stall_struct and busy to 0.
- Reset mid-operation discards all tracked state. Upstream and downstream are reset together.

## Configuration

- BLIMP_ISSUE_WB_BYPASS_EN defined:
  - pend(r) = pending[r] & ~(clr & wb_waddr == r).
  - An instruction whose source or destination is being written back this cycle issues in that same cycle.
  - If it also writes r, the pending bit remains set (set wins).
- BLIMP_ISSUE_WB_BYPASS_EN undefined:
  - pend(r) = pending[r].
  - Dependents issue no earlier than the cycle after writeback.

## Test plan

- Reset: assert rst_n = 0 mid-stream with pending[5] = 1 and cnt[0] = 2 -> all outputs 0 immediately; after release, busy = 0 and an instruction reading x5 issues at once.
- RAW chain: add x5 to pipe 0, then sub x6,x5,x1 the next cycle -> second stalls with stall_raw = 1 until wb_val/wb_waddr = 5; it issues the cycle after (bypass off) or the same cycle (bypass on).
- x0: instruction writing x0 (dec_wen = 1), then an instruction reading x0 -> both issue back-to-back, pending unchanged, busy tracks only cnt.
- Structural: MAX_INFLIGHT = 4, issue 4 to pipe 1 with no cmpl -> fifth gets stall_struct = 1. One cmpl_val[1] -> fifth issues next cycle. Same-cycle issue + cmpl keeps cnt = 4.
- WAW + simultaneous set/clear (bypass on): x7 pending, wb clears x7 while a new writer of x7 fires -> the writer issues and pending[7] = 1 afterward.
- Back-pressure: iss_rdy[2] = 0 with dec_pipe = 2 for 3 cycles -> iss_val = 0, dec_rdy = 0, stall_struct = 1 throughout, no state change. iss_rdy = 1 -> issues.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue bus for issue_scoreboard: decoded instruction, pipe handshake,
// writeback/completion retire ports and status.
interface issue_scoreboard_if #(
  parameter int unsigned NUM_PIPES = 4
);
  localparam int unsigned PW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  logic                 dec_val;
  logic                 dec_rdy;
  logic [4:0]           dec_raddr0;
  logic [4:0]           dec_raddr1;
  logic [4:0]           dec_waddr;
  logic                 dec_wen;
  logic [PW-1:0]        dec_pipe;
  logic [NUM_PIPES-1:0] iss_val;
  logic [NUM_PIPES-1:0] iss_rdy;
  logic                 wb_val;
  logic [4:0]           wb_waddr;
  logic                 wb_wen;
  logic [NUM_PIPES-1:0] cmpl_val;
  logic                 stall_raw;
  logic                 stall_struct;
  logic                 busy;

  // Environment side: decoder, execute pipes and writeback.
  modport mst (
    output dec_val, dec_raddr0, dec_raddr1, dec_waddr, dec_wen, dec_pipe,
    output iss_rdy, wb_val, wb_waddr, wb_wen, cmpl_val,
    input  dec_rdy, iss_val, stall_raw, stall_struct, busy
  );

  // Scoreboard side.
  modport slv (
    input  dec_val, dec_raddr0, dec_raddr1, dec_waddr, dec_wen, dec_pipe,
    input  iss_rdy, wb_val, wb_waddr, wb_wen, cmpl_val,
    output dec_rdy, iss_val, stall_raw, stall_struct, busy
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: RAW/WAW tracking over 32 registers plus per-pipe in-flight limits.
// Define BLIMP_ISSUE_WB_BYPASS_EN to let a same-cycle writeback clear a hazard.
module issue_scoreboard #(
  parameter int unsigned NUM_PIPES    = 4,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input logic             clk,
  input logic             rst_n,
  issue_scoreboard_if.slv sb_if
);
  localparam int unsigned CW   = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned NREG = 32;

  logic [NREG-1:0]      r_pending;
  logic [CW-1:0]        r_cnt [NUM_PIPES];

  logic [NREG-1:0]      w_set_vec;
  logic [NREG-1:0]      w_clr_vec;
  logic [NREG-1:0]      w_pend_eff;
  logic                 w_pipe_ok;
  logic                 w_hz;
  logic                 w_avail;
  logic                 w_fire;
  logic                 w_set;
  logic                 w_clr;
  logic                 w_cnt_nz;
  logic [NUM_PIPES-1:0] w_iss;
  logic [NUM_PIPES-1:0] w_inc;
  logic [NUM_PIPES-1:0] w_dec;

  assign w_pipe_ok = 32'(sb_if.dec_pipe) < NUM_PIPES;

  assign w_clr     = sb_if.wb_val & sb_if.wb_wen & (sb_if.wb_waddr != 5'd0);
  assign w_clr_vec = w_clr ? (NREG'(1) << sb_if.wb_waddr) : '0;

`ifdef BLIMP_ISSUE_WB_BYPASS_EN
  assign w_pend_eff = r_pending & ~w_clr_vec;
`else
  assign w_pend_eff = r_pending;
`endif

  // Bit 0 of r_pending is held at zero, so x0 never creates a dependency.
  assign w_hz = w_pend_eff[sb_if.dec_raddr0] | w_pend_eff[sb_if.dec_raddr1] |
                (sb_if.dec_wen & w_pend_eff[sb_if.dec_waddr]);

  assign w_avail = w_pipe_ok && sb_if.iss_rdy[sb_if.dec_pipe] &&
                   (r_cnt[sb_if.dec_pipe] < CW'(MAX_INFLIGHT));

  assign w_fire    = sb_if.dec_val & ~w_hz & w_avail;
  assign w_iss     = w_fire ? (NUM_PIPES'(1) << sb_if.dec_pipe) : '0;
  assign w_set     = w_fire & sb_if.dec_wen & (sb_if.dec_waddr != 5'd0);
  assign w_set_vec = w_set ? (NREG'(1) << sb_if.dec_waddr) : '0;

  always_comb begin
    w_inc    = '0;
    w_dec    = '0;
    w_cnt_nz = 1'b0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      w_inc[p] = w_iss[p] & sb_if.iss_rdy[p];
      w_dec[p] = sb_if.cmpl_val[p] & (r_cnt[p] != '0);
      w_cnt_nz = w_cnt_nz | (r_cnt[p] != '0);
    end
  end

  // Set wins over clear of the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_clr_vec) | w_set_vec) & ~NREG'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PIPES; p++) r_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        if (w_inc[p] && !w_dec[p])      r_cnt[p] <= r_cnt[p] + CW'(1);
        else if (!w_inc[p] && w_dec[p]) r_cnt[p] <= r_cnt[p] - CW'(1);
      end
    end
  end

  // Outputs are forced low while reset is held.
  assign sb_if.dec_rdy      = rst_n & w_fire;
  assign sb_if.iss_val      = rst_n ? w_iss : '0;
  assign sb_if.stall_raw    = rst_n & sb_if.dec_val & w_hz;
  assign sb_if.stall_struct = rst_n & sb_if.dec_val & ~w_hz & ~w_avail;
  assign sb_if.busy         = rst_n & ((|r_pending) | w_cnt_nz);

  a_pipe_legal: assert property (@(posedge clk) disable iff (!rst_n)
    sb_if.dec_val |-> w_pipe_ok);

  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_chk
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      sb_if.cmpl_val[p] |-> (r_cnt[p] != '0));
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: vector table through an expected-value
// queue, plus a hand-written mid-stream reset sequence.
module tb_issue_scoreboard;
`ifdef BLIMP_ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;

  issue_scoreboard_if #(.NUM_PIPES(4)) sb_if();

  issue_scoreboard #(.NUM_PIPES(4), .MAX_INFLIGHT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb_if (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [4:0] r0;
    logic [4:0] r1;
    logic [4:0] wa;
    logic       we;
    logic [1:0] pp;
    logic [3:0] rdy;
    logic       wbv;
    logic [4:0] wba;
    logic       wbw;
    logic [3:0] cmpl;
    logic [7:0] exp;   // {dec_rdy, iss_val[3:0], stall_raw, stall_struct, busy}
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  function automatic vec_t mk(input logic dv, input logic [4:0] r0, input logic [4:0] r1,
                              input logic [4:0] wa, input logic we, input logic [1:0] pp,
                              input logic [3:0] rdy, input logic wbv, input logic [4:0] wba,
                              input logic wbw, input logic [3:0] cmpl,
                              input logic e_rdy, input logic [3:0] e_iss, input logic e_raw,
                              input logic e_str, input logic e_busy);
    vec_t v;
    v.dv = dv; v.r0 = r0; v.r1 = r1; v.wa = wa; v.we = we; v.pp = pp; v.rdy = rdy;
    v.wbv = wbv; v.wba = wba; v.wbw = wbw; v.cmpl = cmpl;
    v.exp = {e_rdy, e_iss, e_raw, e_str, e_busy};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    sb_if.dec_val    = v.dv;
    sb_if.dec_raddr0 = v.r0;
    sb_if.dec_raddr1 = v.r1;
    sb_if.dec_waddr  = v.wa;
    sb_if.dec_wen    = v.we;
    sb_if.dec_pipe   = v.pp;
    sb_if.iss_rdy    = v.rdy;
    sb_if.wb_val     = v.wbv;
    sb_if.wb_waddr   = v.wba;
    sb_if.wb_wen     = v.wbw;
    sb_if.cmpl_val   = v.cmpl;
  endtask

  function automatic logic [7:0] sample();
    return {sb_if.dec_rdy, sb_if.iss_val, sb_if.stall_raw, sb_if.stall_struct, sb_if.busy};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {rdy,iss,raw,struct,busy}=%b want %b", name, got, exp);
    end
  endtask

  initial begin
    vec_t idle;
    logic [7:0] e;
    idle = mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    drive(idle);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state, then RAW chain: add x5 <- x1,x2 ; sub x6 <- x5,x1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 2, 5, 1, 0, 4'hF, 0, 0, 0, 4'h0, 1, 4'h1, 0, 0, 0));
    vecs.push_back(mk(1, 5, 1, 6, 1, 0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 1, 0, 1));
    vecs.push_back(mk(1, 5, 1, 6, 1, 0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 1, 0, 1));
    vecs.push_back(mk(1, 5, 1, 6, 1, 0, 4'hF, 1, 5, 1, 4'h1,
                      BYP, BYP ? 4'h1 : 4'h0, !BYP, 0, 1));
    vecs.push_back(mk(!BYP, 5, 1, 6, 1, 0, 4'hF, 0, 0, 0, 4'h0,
                      !BYP, BYP ? 4'h0 : 4'h1, 0, 0, BYP));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 1, 6, 1, 4'h1, 0, 4'h0, 0, 0, 1));
    // x0: a writer then a reader of x0 issue back-to-back, nothing becomes pending
    vecs.push_back(mk(1, 0, 0, 0, 1, 3, 4'hF, 0, 0, 0, 4'h0, 1, 4'h8, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 9, 0, 3, 4'hF, 0, 0, 0, 4'h0, 1, 4'h8, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h8, 0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h8, 0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
    // Structural: fill pipe 1, then stall, same-cycle cmpl does not unblock
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4'hF, 0, 0, 0, 4'h0, 1, 4'h2, 0, 0, k != 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4'hF, 0, 0, 0, 4'h2, 0, 4'h0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4'hF, 0, 0, 0, 4'h2, 1, 4'h2, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4'hF, 0, 0, 0, 4'h0, 1, 4'h2, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 1, 1));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h2, 0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
    // Back-pressure on pipe 2 for three cycles, then release
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 3, 4, 8, 1, 2, 4'hB, 0, 0, 0, 4'h0, 0, 4'h0, 0, 1, 0));
    vecs.push_back(mk(1, 3, 4, 8, 1, 2, 4'hF, 0, 0, 0, 4'h0, 1, 4'h4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 1, 8, 1, 4'h4, 0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
    // WAW on x7 with a same-cycle writeback of x7
    vecs.push_back(mk(1, 0, 0, 7, 1, 0, 4'hF, 0, 0, 0, 4'h0, 1, 4'h1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 7, 1, 1, 4'hF, 1, 7, 1, 4'h0,
                      BYP, BYP ? 4'h2 : 4'h0, !BYP, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, BYP ? 4'h3 : 4'h1, 0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, BYP));
    vecs.push_back(mk(1, 7, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h0,
                      !BYP, BYP ? 4'h0 : 4'h1, BYP, 0, BYP));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 1, 7, 1, BYP ? 4'h0 : 4'h1, 0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      exp_q.push_back(vecs[i].exp);
      #3;
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), sample(), e);
      @(posedge clk);
      #1;
    end

    // Mid-stream reset with pending[5] = 1 and cnt[0] = 2
    drive(mk(1, 1, 2, 5, 1, 0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
    #3 check("rst_setup_w5", sample(), 8'b1_0001_000);
    @(posedge clk); #1;
    drive(mk(1, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
    #3 check("rst_setup_p0", sample(), 8'b1_0001_001);
    @(posedge clk); #1;
    drive(mk(1, 5, 0, 0, 0, 1, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
    #1 check("rst_pre_raw", sample(), 8'b0_0000_101);
    #1 rst_n = 1'b0;
    #1 check("rst_force_zero", sample(), 8'b0_0000_000);
    @(posedge clk); #1;
    check("rst_held", sample(), 8'b0_0000_000);
    rst_n = 1'b1;
    #1 check("rst_release_issue_x5", sample(), 8'b1_0010_000);
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h2, 0, 4'h0, 0, 0, 0));
    #3 check("rst_after_busy", sample(), 8'b0_0000_001);
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
    #3 check("final_idle", sample(), 8'b0_0000_000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
